// File: rtl/demux_narrow_wide.sv
// Packs RATIO IN_W-bit beats into one OUT_W-bit word, lane order set by MSB_FIRST.
// Latency: word registered one cycle after its closing beat (or the timeout flush).
// Backpressure: in_ready = !out_valid || out_ready; the output register is the only stall point.
//
// Ports:
//   clk_4f, reset            - sole clock (rising edge), async active-high reset
//   in_data/in_valid/in_last - narrow beat stream, in_ready accepts it
//   out_data/out_keep        - assembled word, lane i = out_data[i*IN_W +: IN_W], keep[i] = lane received
//   out_valid/out_last       - word valid, word closed by in_last or idle timeout
//   out_ready                - downstream accept
module demux_narrow_wide #(
    parameter int IN_W          = 8,
    parameter int RATIO         = 4,
    parameter int MSB_FIRST     = 1,
    parameter int FLUSH_TIMEOUT = 4,
    parameter int PAD           = 0
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [IN_W*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]        out_keep,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);

    localparam int OUT_W  = IN_W * RATIO;
    localparam int CNT_W  = $clog2(RATIO);
    localparam int IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    localparam logic [IN_W-1:0]   PAD_LANE = IN_W'(PAD);
    localparam logic [OUT_W-1:0]  PAD_WORD = {RATIO{PAD_LANE}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);

    // Accumulator for the word being built, plus its lane occupancy.
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [RATIO-1:0]  keep_q, keep_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Output register.
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [RATIO-1:0]  out_keep_q, out_keep_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              out_free;
    logic              accept;
    logic              close;
    logic              timeout;
    logic [CNT_W-1:0]  lane;
    logic [OUT_W-1:0]  acc_beat;
    logic [RATIO-1:0]  keep_beat;

    always_comb begin
        out_free = !out_valid_q || out_ready;
        accept   = in_valid && out_free;

        lane = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;

        // Accumulator as it would look with the current beat merged in.
        acc_beat  = acc_q;
        keep_beat = keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == CNT_W'(i)) begin
                acc_beat[i*IN_W +: IN_W] = in_data;
                keep_beat[i]             = 1'b1;
            end
        end

        close = accept && (in_last || (cnt_q == CNT_LAST));

        // An accepted beat resets the idle count, so a flush can only fire on a
        // beat-free cycle; it also waits for the output register to be free.
        timeout = (FLUSH_TIMEOUT > 0) && !accept && (cnt_q != '0)
                  && (idle_q == IDLE_MAX) && out_free;

        acc_d       = acc_q;
        keep_d      = keep_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;

        if (close) begin
            out_data_d  = acc_beat;
            out_keep_d  = keep_beat;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            acc_d       = PAD_WORD;
            keep_d      = '0;
            cnt_d       = '0;
            idle_d      = '0;
        end else if (accept) begin
            acc_d  = acc_beat;
            keep_d = keep_beat;
            cnt_d  = cnt_q + CNT_W'(1);
            idle_d = '0;
        end else if (timeout) begin
            out_data_d  = acc_q;
            out_keep_d  = keep_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = PAD_WORD;
            keep_d      = '0;
            cnt_d       = '0;
            idle_d      = '0;
        end else if (cnt_q == '0) begin
            idle_d = '0;
        end else if ((FLUSH_TIMEOUT > 0) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            acc_q       <= PAD_WORD;
            keep_q      <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = out_free;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_demux_narrow_wide.sv
// Bench for demux_narrow_wide: default MSB-first instance, an LSB-first twin on the same stimulus,
// and a 16-bit RATIO=2 instance with the timeout disabled.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_demux_narrow_wide;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Shared stimulus for instances A (MSB first) and B (LSB first).
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, b_in_ready;
    logic [31:0] a_out_data, b_out_data;
    logic [3:0]  a_out_keep, b_out_keep;
    logic        a_out_valid, b_out_valid, a_out_last, b_out_last;

    // Instance C: IN_W=16, RATIO=2, no timeout.
    logic [15:0] c_in_data = '0;
    logic        c_in_valid = 1'b0;
    logic        c_in_last = 1'b0;
    logic        c_in_ready;
    logic [31:0] c_out_data;
    logic [1:0]  c_out_keep;
    logic        c_out_valid, c_out_last;
    logic        c_out_ready = 1'b1;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_narrow_wide dut_a (
        .clk_4f(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_keep(a_out_keep), .out_valid(a_out_valid),
        .out_last(a_out_last), .out_ready(out_ready)
    );

    demux_narrow_wide #(.MSB_FIRST(0)) dut_b (
        .clk_4f(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_keep(b_out_keep), .out_valid(b_out_valid),
        .out_last(b_out_last), .out_ready(out_ready)
    );

    demux_narrow_wide #(.IN_W(16), .RATIO(2), .FLUSH_TIMEOUT(0)) dut_c (
        .clk_4f(clk), .reset(reset),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_keep(c_out_keep), .out_valid(c_out_valid),
        .out_last(c_out_last), .out_ready(c_out_ready)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ab(input logic [31:0] da, input logic [31:0] db,
                             input logic [3:0] ka, input logic [3:0] kb, input logic l);
        qa.push_back('{data: da, keep: ka, last: l});
        qb.push_back('{data: db, keep: kb, last: l});
    endtask

    task automatic send_a(input logic [7:0] d, input logic l);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_a_accepted", 32'(done), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_c(input logic [15:0] d);
        logic done;
        done       = 1'b0;
        c_in_valid = 1'b1;
        c_in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = c_in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_c_accepted", 32'(done), 32'd1);
        c_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    endtask

    // Monitors: a word transfers on the next rising edge when valid && ready at the falling edge.
    always @(negedge clk) begin
        if (!reset && a_out_valid && out_ready) begin
            chk("a_word_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_data", a_out_data, ea.data);
                chk("a_keep", 32'(a_out_keep), 32'(ea.keep));
                chk("a_last", 32'(a_out_last), 32'(ea.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_out_valid && out_ready) begin
            chk("b_word_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_data", b_out_data, eb.data);
                chk("b_keep", 32'(b_out_keep), 32'(eb.keep));
                chk("b_last", 32'(b_out_last), 32'(eb.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && c_out_valid && c_out_ready) begin
            chk("c_word_expected", 32'(qc.size() != 0), 32'd1);
            if (qc.size() != 0) begin
                ec = qc.pop_front();
                chk("c_data", c_out_data, ec.data);
                chk("c_keep", 32'(c_out_keep), 32'(ec.keep[1:0]));
                chk("c_last", 32'(c_out_last), 32'(ec.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_data", a_out_data, 32'h0);
        chk("rst_a_keep", 32'(a_out_keep), 32'h0);
        chk("rst_a_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_last", 32'(a_out_last), 32'h0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'h1);
        chk("rst_b_data", b_out_data, 32'h0);
        chk("rst_c_data", c_out_data, 32'h0);
        sync();
        reset = 1'b0;
        sync();

        // Full word, valid for exactly one cycle.
        expect_ab(32'hAABBCCDD, 32'hDDCCBBAA, 4'hF, 4'hF, 1'b0);
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b0);
        send_a(8'hCC, 1'b0);
        send_a(8'hDD, 1'b0);
        @(negedge clk);
        chk("t1_valid_next_cycle", 32'(a_out_valid), 32'd1);
        @(negedge clk);
        chk("t1_valid_one_cycle", 32'(a_out_valid), 32'd0);
        drain("t1_drain");

        // Partial word flushed by idle timeout: idle count reaches 4 on the 4th
        // beat-free edge, the flush loads on the 5th, visible at the 6th falling edge.
        sync();
        expect_ab(32'h11220000, 32'h00002211, 4'hC, 4'h3, 1'b1);
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        begin
            int early;
            early = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (a_out_valid) early++;
            end
            chk("t2_no_early_flush", 32'(early), 32'd0);
            @(negedge clk);
            chk("t2_flush_valid", 32'(a_out_valid), 32'd1);
        end
        drain("t2_drain");

        // in_last closes a 3-beat word, then a normal full word.
        sync();
        expect_ab(32'h01020300, 32'h00030201, 4'hE, 4'h7, 1'b1);
        expect_ab(32'h10111213, 32'h13121110, 4'hF, 4'hF, 1'b0);
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h03, 1'b1);
        @(negedge clk);
        chk("t3_last_latency", 32'(a_out_valid), 32'd1);
        chk("t3_last_flag", 32'(a_out_last), 32'd1);
        sync();
        for (int k = 0; k < 4; k++) send_a(8'(8'h10 + k), 1'b0);
        drain("t3_drain");

        // Back-pressure: first word must hold and stall input until released.
        sync();
        out_ready = 1'b0;
        expect_ab(32'h00010203, 32'h03020100, 4'hF, 4'hF, 1'b0);
        expect_ab(32'h04050607, 32'h07060504, 4'hF, 4'hF, 1'b0);
        fork
            begin
                for (int k = 0; k < 8; k++) send_a(8'(k), 1'b0);
            end
            begin
                int bad;
                bad = 0;
                for (int i = 0; i < 20 && !a_out_valid; i++) @(negedge clk);
                chk("t4_word_valid", 32'(a_out_valid), 32'd1);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (!a_out_valid || a_out_data !== 32'h00010203 || a_out_keep !== 4'hF
                        || a_in_ready || b_out_data !== 32'h03020100) bad++;
                end
                chk("t4_hold_stable", 32'(bad), 32'd0);
                sync();
                out_ready = 1'b1;
            end
        join
        drain("t4_drain");

        // Reset mid-word discards partial beats.
        sync();
        send_a(8'h55, 1'b0);
        send_a(8'h66, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_a_data", a_out_data, 32'h0);
        chk("t5_rst_a_keep", 32'(a_out_keep), 32'h0);
        chk("t5_rst_a_valid", 32'(a_out_valid), 32'h0);
        chk("t5_rst_b_data", b_out_data, 32'h0);
        sync();
        reset = 1'b0;
        sync();
        expect_ab(32'h01020304, 32'h04030201, 4'hF, 4'hF, 1'b0);
        for (int k = 1; k <= 4; k++) send_a(8'(k), 1'b0);
        drain("t5_drain");

        // Wide instance, timeout disabled: a lone beat waits indefinitely.
        sync();
        qc.push_back('{data: 32'hBEEFCAFE, keep: 4'h3, last: 1'b0});
        send_c(16'hBEEF);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (c_out_valid) seen++;
            end
            chk("t6_no_timeout_flush", 32'(seen), 32'd0);
        end
        sync();
        send_c(16'hCAFE);
        @(negedge clk);
        chk("t6_word_valid", 32'(c_out_valid), 32'd1);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
